clk_div_gen: RTL

//   Parametrised successor to the SoC clock divider. Keeps the free-running

---
 rtl/clk_div_pkg.sv | 7 +
 rtl/clk_div_chan.sv | 32 +++
 rtl/clk_div_gen.sv | 63 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode encodings for the clock-enable generator
package clk_div_pkg;
  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SLOW  = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_CHAN0 = 2'd3;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable enable channel, pulse every div+1 cycles plus a toggle
module clk_div_chan #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             en,
  output logic             tog
);
  logic [DIV_W-1:0] div, cnt;
  // a load beats a same-cycle terminal count, so that pulse is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      cnt <= '0;
      en  <= 1'b0;
      tog <= 1'b0;
    end else if (load) begin
      div <= load_div;
      cnt <= load_div;
      en  <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= div;
      en  <= 1'b1;
      tog <= ~tog;
    end else begin
      cnt <= cnt - DIV_W'(1);
      en  <= 1'b0;
    end
endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: free-running divide counter, programmable enable channels and CPU enable
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int NCH      = 4,
  parameter int DIV_W    = 16,
  parameter int SLOW_TAP = 24,
  localparam int CH_W    = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic [CNT_W-1:0] clkdiv,
  output logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   ch_tog,
  output logic             cpu_en
);
  logic [NCH-1:0] load;
  logic [1:0]     mode_q;
  logic [2:0]     step_q;
  logic           slow_q;
  logic           cpu_next;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load[i] = cfg_we && int'(cfg_ch) == i;
    clk_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .load_div (cfg_div),
      .en       (ch_en[i]),
      .tog      (ch_tog[i])
    );
  end
  // step_q[1:0] is the synchroniser, step_q[2] the edge-detect history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clkdiv  <= '0;
      cfg_ack <= 1'b0;
      mode_q  <= MODE_RUN;
      step_q  <= '0;
      slow_q  <= 1'b0;
      cpu_en  <= 1'b0;
    end else begin
      clkdiv  <= clkdiv + CNT_W'(1);
      cfg_ack <= cfg_we && int'(cfg_ch) < NCH;
      mode_q  <= mode;
      step_q  <= {step_q[1:0], step};
      slow_q  <= clkdiv[SLOW_TAP];
      cpu_en  <= cpu_next;
    end
  always_comb
    cpu_next = mode != mode_q       ? 1'b0 :
               mode_q == MODE_RUN   ? 1'b1 :
               mode_q == MODE_SLOW  ? clkdiv[SLOW_TAP] & ~slow_q :
               mode_q == MODE_STEP  ? step_q[1] & ~step_q[2] :
                                      ch_en[0];
endmodule
